// File: rtl/mips_run_monitor.sv
// mips_run_monitor: run control with halt/timeout detection, then register-file dump over valid/ready
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   start               one-cycle pulse starting a run (accepted in IDLE or DONE)
//   pc                  live program counter of the core
//   rf_raddr, rf_rdata  spare register-file read port (combinational read)
//   dump_valid/ready    handshake for the register dump stream
//   dump_idx/dump_data  index and value of the presented register
//   final_pc, cycles    PC at the end of the run and RUN cycle count
//   busy, done, timeout status: active, finished, run ended by cycle limit
module mips_run_monitor #(
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int IDX_W         = 5,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 4096,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [DATA_W-1:0] final_pc,
  output logic [CNT_W-1:0]  cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  typedef enum logic [2:0] {IDLE, RUN, DUMP_RD, DUMP_OUT, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] pc_prev;
  logic [CNT_W-1:0] stable_cnt, stable_inc, cycles_inc;
  logic [IDX_W-1:0] idx;
  logic same, halt, tmo, ended, hs, last;
  // halt and timeout are judged on the values the counters would take on this edge
  always_comb begin
    same       = pc == pc_prev;
    stable_inc = stable_cnt + 1'b1;
    cycles_inc = &cycles ? cycles : cycles + 1'b1;
    halt       = same && stable_inc == CNT_W'(STABLE_CYCLES);
    tmo        = cycles_inc == CNT_W'(MAX_CYCLES);
    ended      = halt || tmo;
    hs         = dump_valid && dump_ready;
    last       = idx == IDX_W'(NUM_REGS - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : state;
      RUN:        state_nx = ended ? DUMP_RD : RUN;
      DUMP_RD:    state_nx = DUMP_OUT;
      DUMP_OUT:   state_nx = hs ? (last ? DONE : DUMP_RD) : DUMP_OUT;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN || state == DUMP_RD || state == DUMP_OUT;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_prev    <= '0;
      stable_cnt <= '0;
      idx        <= '0;
      cycles     <= '0;
      final_pc   <= '0;
      timeout    <= 1'b0;
      rf_raddr   <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          cycles     <= '0;
          stable_cnt <= '0;
          timeout    <= 1'b0;
          idx        <= '0;
          pc_prev    <= pc;
        end
        RUN: begin
          cycles     <= cycles_inc;
          stable_cnt <= same ? stable_inc : '0;
          pc_prev    <= pc;
          if (ended) begin
            final_pc <= pc;
            rf_raddr <= '0;
            timeout  <= tmo && !halt;
          end
        end
        DUMP_RD: begin
          dump_data  <= rf_rdata;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
        end
        DUMP_OUT: if (hs) begin
          dump_valid <= 1'b0;
          if (!last) begin
            idx      <= idx + 1'b1;
            rf_raddr <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
